reload_sequencer: RTL

RELOAD_SEQUENCER -- requirements
Module: reload_sequencer

---
 rtl/reload_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reload_sequencer.sv
// Reload sequencer: walks a small table of reload values, strobing each nonzero
// entry into a downstream down-counter and waiting for it to count out.
module reload_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned LOOP      = 0
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Start,
  input  logic                         Stop,
  input  logic                         CfgWe,
  input  logic [$clog2(NUM_SLOTS)-1:0] CfgAddr,
  input  logic [WIDTH-1:0]             CfgData,
  input  logic [WIDTH-1:0]             CountIn,
  output logic [WIDTH-1:0]             LoadValue,
  output logic                         Load,
  output logic                         Busy,
  output logic                         Done,
  output logic [$clog2(NUM_SLOTS)-1:0] Slot
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ARM     = 3'd2,
    RUN     = 3'd3,
    ADVANCE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   table_q [NUM_SLOTS];
  logic [WIDTH-1:0]   cur_entry;
  logic               arm_q, arm_d;
  logic               load_d, busy_d, done_d;
  logic [WIDTH-1:0]   load_value_d;
  logic [SLOT_W-1:0]  slot_d;

  assign cur_entry = table_q[Slot];

  // Reload table, writable in any state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      table_q <= '{default: '0};
    end else if (CfgWe) begin
      table_q[CfgAddr] <= CfgData;
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d      = state_q;
    arm_d        = arm_q;
    load_d       = 1'b0;
    done_d       = 1'b0;
    busy_d       = Busy;
    slot_d       = Slot;
    load_value_d = LoadValue;

    if (state_q != IDLE && Stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      slot_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Stop) begin
            state_d = LOAD;
            busy_d  = 1'b1;
            slot_d  = '0;
          end
        end
        LOAD: begin
          if (cur_entry != '0) begin
            load_d       = 1'b1;
            load_value_d = cur_entry;
            arm_d        = 1'b0;
            state_d      = ARM;
          end else begin
            state_d = ADVANCE;
          end
        end
        // Two cycles of reload latency before CountIn is trusted
        ARM: begin
          arm_d = 1'b1;
          if (arm_q) state_d = RUN;
        end
        RUN: begin
          if (CountIn == '0) state_d = ADVANCE;
        end
        ADVANCE: begin
          slot_d  = Slot + SLOT_W'(1);
          state_d = LOAD;
          if (Slot == LAST_SLOT) begin
            done_d = 1'b1;
            if (LOOP == 0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      arm_q     <= 1'b0;
      Load      <= 1'b0;
      LoadValue <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Slot      <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      Load      <= load_d;
      LoadValue <= load_value_d;
      Busy      <= busy_d;
      Done      <= done_d;
      Slot      <= slot_d;
    end
  end

endmodule
